// File: rtl/block_collide_check_if.sv
// Request/verdict and board-row-read signals between the game controller, the board
// row memory and block_collide_check.
interface block_collide_check_if #(
    parameter int BOARD_W = 10,
    parameter int XW      = 6,
    parameter int AW      = 5
);
    logic                 start;
    logic [15:0]          block_matrix;
    logic signed [XW-1:0] pos_x;
    logic signed [XW-1:0] pos_y;
    logic                 row_rd;
    logic [AW-1:0]        row_addr;
    logic [BOARD_W-1:0]   row_data;
    logic                 busy;
    logic                 done;
    logic                 collide;

    modport master (
        output start, block_matrix, pos_x, pos_y, row_data,
        input  row_rd, row_addr, busy, done, collide
    );

    modport slave (
        input  start, block_matrix, pos_x, pos_y, row_data,
        output row_rd, row_addr, busy, done, collide
    );
endinterface

// File: rtl/block_collide_check.sv
// Checks a 4x4 piece mask at (pos_x,pos_y) against the board by scanning four rows of a
// synchronous-read row memory. Optional COLLIDE_EARLY_EXIT_EN ends the scan on the first hit.
module block_collide_check #(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20,
    parameter int XW      = 6,
    parameter int AW      = 5
) (
    input logic                  clk,
    input logic                  rst_n,
    block_collide_check_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;

    localparam logic signed [XW:0] BW_S = (XW+1)'(BOARD_W);
    localparam logic signed [XW:0] BH_S = (XW+1)'(BOARD_H);

    state_t               state;
    logic [2:0]           cnt;
    logic [15:0]          mask_p0;
    logic signed [XW-1:0] px_p0;
    logic signed [XW-1:0] py_p0;
    logic                 row_rd_q;
    logic [AW-1:0]        row_addr_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 collide_q;

    logic [1:0]           iss_r;
    logic [1:0]           ev_r;
    logic [3:0]           iss_mrow;
    logic signed [XW:0]   iss_y;
    logic                 iss_en;
    logic                 ev_hit;
    logic                 accept;

    function automatic logic [3:0] mask_row(input logic [15:0] m, input logic [1:0] r);
        logic [3:0] v;
        case (r)
            2'd0:    v = m[15:12];
            2'd1:    v = m[11:8];
            2'd2:    v = m[7:4];
            default: v = m[3:0];
        endcase
        return v;
    endfunction

    function automatic logic signed [XW:0] row_y(input logic signed [XW-1:0] py,
                                                 input logic [1:0] r);
        return $signed({py[XW-1], py}) + $signed({{(XW-1){1'b0}}, r});
    endfunction

    // Row collides if it is non-empty and off the board vertically, or any set cell is
    // off the board horizontally or lands on a filled cell.
    function automatic logic row_hit(input logic [3:0]           mrow,
                                     input logic signed [XW:0]   y,
                                     input logic signed [XW-1:0] px,
                                     input logic [BOARD_W-1:0]   rd);
        logic               hit;
        logic signed [XW:0] x;
        hit = 1'b0;
        if (mrow != 4'd0) begin
            if (y[XW] || (y >= BH_S)) hit = 1'b1;
            for (int c = 0; c < 4; c++) begin
                if (mrow[3-c]) begin
                    x = $signed({px[XW-1], px}) + $signed((XW+1)'(c));
                    if (x[XW] || (x >= BW_S)) begin
                        hit = 1'b1;
                    end else begin
                        for (int i = 0; i < BOARD_W; i++)
                            if ((x == $signed((XW+1)'(i))) && rd[i]) hit = 1'b1;
                    end
                end
            end
        end
        return hit;
    endfunction

    assign accept = ((state == IDLE) || (state == DONE)) && bus.start;

    // Issue side uses live inputs for row 0 at acceptance, latched request afterwards.
    always_comb begin
        iss_r = cnt[1:0] + 2'd1;
        ev_r  = cnt[1:0] - 2'd1;
        if ((state == IDLE) || (state == DONE)) begin
            iss_mrow = mask_row(bus.block_matrix, 2'd0);
            iss_y    = row_y(bus.pos_y, 2'd0);
        end else begin
            iss_mrow = mask_row(mask_p0, iss_r);
            iss_y    = row_y(py_p0, iss_r);
        end
        iss_en = (iss_mrow != 4'd0) && !iss_y[XW] && (iss_y < BH_S);
        ev_hit = row_hit(mask_row(mask_p0, ev_r), row_y(py_p0, ev_r), px_p0, bus.row_data);
    end

    // p0: request latched at acceptance
    always_ff @(posedge clk) begin
        if (accept) begin
            mask_p0 <= bus.block_matrix;
            px_p0   <= bus.pos_x;
            py_p0   <= bus.pos_y;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            collide_q  <= 1'b0;
            row_rd_q   <= 1'b0;
            row_addr_q <= '0;
        end else begin
            done_q   <= 1'b0;
            row_rd_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    if (bus.start) begin
                        state     <= SCAN;
                        cnt       <= 3'd0;
                        busy_q    <= 1'b1;
                        collide_q <= 1'b0;
                        if (iss_en) begin
                            row_rd_q   <= 1'b1;
                            row_addr_q <= iss_y[AW-1:0];
                        end
                    end
                end
                SCAN: begin
                    if (iss_en) begin
                        row_rd_q   <= 1'b1;
                        row_addr_q <= iss_y[AW-1:0];
                    end
                    if ((cnt != 3'd0) && ev_hit) collide_q <= 1'b1;
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd2) state <= FLUSH;
`ifdef COLLIDE_EARLY_EXIT_EN
                    if ((cnt != 3'd0) && ev_hit) begin
                        row_rd_q <= 1'b0;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state    <= DONE;
                    end
`endif
                end
                FLUSH: begin
                    if (ev_hit) collide_q <= 1'b1;
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd4) begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= DONE;
                    end
`ifdef COLLIDE_EARLY_EXIT_EN
                    if (ev_hit) begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= DONE;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.row_rd   = row_rd_q;
    assign bus.row_addr = row_addr_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.collide  = collide_q;
endmodule
